// File: rtl/serial_console.sv
// Board-side end of the processor's byte-serial port: switch bytes queue into an RX FIFO
// for the processor, processor-written bytes queue into a TX FIFO drained by a pushbutton.
module serial_console #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_key,
  input  logic          pop_key,
  input  logic [7:0]    sw_data,
  output logic [7:0]    serial_in,
  output logic          serial_valid_in,
  input  logic          serial_rden_out,
  input  logic [7:0]    serial_out,
  input  logic          serial_wren_out,
  output logic          serial_ready_in,
  output logic [7:0]    tx_byte,
  output logic          tx_valid,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count,
  output logic [1:0]    overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    r_pushSync;
  logic [1:0]    r_popSync;
  logic          r_pushPrev;
  logic          r_popPrev;
  logic [7:0]    r_rxMem [DEPTH];
  logic [7:0]    r_txMem [DEPTH];
  logic [AW-1:0] r_rxWr;
  logic [AW-1:0] r_rxRd;
  logic [AW-1:0] r_txWr;
  logic [AW-1:0] r_txRd;
  logic [AW:0]   r_rxCount;
  logic [AW:0]   r_txCount;
  logic [1:0]    r_overflow;

  logic w_pushPulse;
  logic w_popPulse;
  logic w_rxEmpty;
  logic w_rxFull;
  logic w_txEmpty;
  logic w_txFull;
  logic w_rxPush;
  logic w_rxPop;
  logic w_txPush;
  logic w_txPop;

  // Keys idle high, so the synchronisers and edge detectors reset to "released".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pushSync <= 2'b11;
      r_popSync  <= 2'b11;
      r_pushPrev <= 1'b1;
      r_popPrev  <= 1'b1;
    end else begin
      r_pushSync <= {r_pushSync[0], push_key};
      r_popSync  <= {r_popSync[0], pop_key};
      r_pushPrev <= r_pushSync[1];
      r_popPrev  <= r_popSync[1];
    end
  end

  always_comb begin
    w_pushPulse = r_pushPrev & ~r_pushSync[1];
    w_popPulse  = r_popPrev & ~r_popSync[1];
    w_rxEmpty   = (r_rxCount == '0);
    w_rxFull    = (r_rxCount == FULL);
    w_txEmpty   = (r_txCount == '0);
    w_txFull    = (r_txCount == FULL);
    w_rxPush    = w_pushPulse & ~w_rxFull;
    w_rxPop     = serial_rden_out & ~w_rxEmpty;
    w_txPush    = serial_wren_out & ~w_txFull;
    w_txPop     = w_popPulse & ~w_txEmpty;
  end

  // Storage is left unreset; the empty forcing on the outputs hides stale entries.
  always_ff @(posedge clock) begin
    if (w_rxPush) r_rxMem[r_rxWr] <= sw_data;
    if (w_txPush) r_txMem[r_txWr] <= serial_out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rxWr     <= '0;
      r_rxRd     <= '0;
      r_txWr     <= '0;
      r_txRd     <= '0;
      r_rxCount  <= '0;
      r_txCount  <= '0;
      r_overflow <= 2'b00;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCount <= r_rxCount + 1'b1;
        2'b01:   r_rxCount <= r_rxCount - 1'b1;
        default: r_rxCount <= r_rxCount;
      endcase
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + 1'b1;
        2'b01:   r_txCount <= r_txCount - 1'b1;
        default: r_txCount <= r_txCount;
      endcase
      if (w_pushPulse && w_rxFull)     r_overflow[0] <= 1'b1;
      if (serial_wren_out && w_txFull) r_overflow[1] <= 1'b1;
    end
  end

  always_comb begin
    serial_in       = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRd];
    serial_valid_in = ~w_rxEmpty;
    serial_ready_in = ~w_txFull;
    tx_byte         = w_txEmpty ? 8'h00 : r_txMem[r_txRd];
    tx_valid        = ~w_txEmpty;
    rx_count        = r_rxCount;
    tx_count        = r_txCount;
    overflow        = r_overflow;
  end

endmodule

// File: tb/tb_serial_console.sv
// Randomised and directed bench for serial_console against a queue-based model
// of the two FIFOs and the key press timing.
module tb_serial_console;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pushKey;
  logic          popKey;
  logic [7:0]    swData;
  logic [7:0]    serialIn;
  logic          serialValidIn;
  logic          serialRdenOut;
  logic [7:0]    serialOut;
  logic          serialWrenOut;
  logic          serialReadyIn;
  logic [7:0]    txByte;
  logic          txValid;
  logic [AW:0]   rxCount;
  logic [AW:0]   txCount;
  logic [1:0]    overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];
  logic [1:0] modelOvf;
  bit         pushHist [3];
  bit         popHist [3];

  serial_console #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock),
    .reset(reset),
    .push_key(pushKey),
    .pop_key(popKey),
    .sw_data(swData),
    .serial_in(serialIn),
    .serial_valid_in(serialValidIn),
    .serial_rden_out(serialRdenOut),
    .serial_out(serialOut),
    .serial_wren_out(serialWrenOut),
    .serial_ready_in(serialReadyIn),
    .tx_byte(txByte),
    .tx_valid(txValid),
    .rx_count(rxCount),
    .tx_count(txCount),
    .overflow(overflow)
  );

  // 10 ns clock; inputs change 1 ns after the rising edge.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    rxQ.delete();
    txQ.delete();
    modelOvf = 2'b00;
    for (int i = 0; i < 3; i++) begin
      pushHist[i] = 1'b1;
      popHist[i]  = 1'b1;
    end
  endtask

  // A press counts once: the key was high three edges ago and low two edges ago.
  task automatic updateModel();
    bit pushPulse;
    bit popPulse;
    bit rxPushOk;
    bit rxPopOk;
    bit txPushOk;
    bit txPopOk;
    pushPulse = !pushHist[1] && pushHist[2];
    popPulse  = !popHist[1] && popHist[2];
    rxPushOk  = pushPulse && (rxQ.size() < DEPTH);
    rxPopOk   = (serialRdenOut === 1'b1) && (rxQ.size() > 0);
    txPushOk  = (serialWrenOut === 1'b1) && (txQ.size() < DEPTH);
    txPopOk   = popPulse && (txQ.size() > 0);
    if (pushPulse && !rxPushOk) modelOvf[0] = 1'b1;
    if ((serialWrenOut === 1'b1) && !txPushOk) modelOvf[1] = 1'b1;
    if (rxPopOk) void'(rxQ.pop_front());
    if (rxPushOk) rxQ.push_back(swData);
    if (txPopOk) void'(txQ.pop_front());
    if (txPushOk) txQ.push_back(serialOut);
    pushHist[2] = pushHist[1];
    pushHist[1] = pushHist[0];
    pushHist[0] = pushKey;
    popHist[2]  = popHist[1];
    popHist[1]  = popHist[0];
    popHist[0]  = popKey;
  endtask

  task automatic compareAll();
    checkOutput("serial_in", 32'(serialIn), 32'((rxQ.size() > 0) ? rxQ[0] : 8'h00));
    checkOutput("serial_valid_in", 32'(serialValidIn), 32'(rxQ.size() > 0));
    checkOutput("serial_ready_in", 32'(serialReadyIn), 32'(txQ.size() < DEPTH));
    checkOutput("tx_byte", 32'(txByte), 32'((txQ.size() > 0) ? txQ[0] : 8'h00));
    checkOutput("tx_valid", 32'(txValid), 32'(txQ.size() > 0));
    checkOutput("rx_count", 32'(rxCount), 32'(rxQ.size()));
    checkOutput("tx_count", 32'(txCount), 32'(txQ.size()));
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic applyStimulus();
    @(posedge clock);
    if (!reset) resetModel();
    else updateModel();
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pressPush(input logic [7:0] data);
    swData  = data;
    pushKey = 1'b0;
    idle(3);
    pushKey = 1'b1;
    idle(2);
  endtask

  task automatic pressPop();
    popKey = 1'b0;
    idle(3);
    popKey = 1'b1;
    idle(2);
  endtask

  task automatic writeTx(input logic [7:0] data);
    serialOut     = data;
    serialWrenOut = 1'b1;
    applyStimulus();
    serialWrenOut = 1'b0;
  endtask

  task automatic readRx();
    serialRdenOut = 1'b1;
    applyStimulus();
    serialRdenOut = 1'b0;
  endtask

  // Pop pulse acts on the third edge of the press; the write is lined up with it.
  task automatic popWithWrite(input logic [7:0] data);
    popKey = 1'b0;
    idle(2);
    writeTx(data);
    popKey = 1'b1;
    idle(2);
  endtask

  task automatic doReset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    logic [7:0] data;
    reset         = 1'b0;
    pushKey       = 1'b1;
    popKey        = 1'b1;
    swData        = 8'h00;
    serialRdenOut = 1'b0;
    serialOut     = 8'h00;
    serialWrenOut = 1'b0;
    resetModel();
    idle(3);
    checkOutput("rst_ready", 32'(serialReadyIn), 32'd1);
    checkOutput("rst_valid", 32'(serialValidIn), 32'd0);
    checkOutput("rst_rxcount", 32'(rxCount), 32'd0);
    checkOutput("rst_txcount", 32'(txCount), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_serial_in", 32'(serialIn), 32'h00);
    checkOutput("rst_tx_byte", 32'(txByte), 32'h00);
    reset = 1'b1;
    idle(2);

    $display("[TB] RX order and key latency");
    swData  = 8'hA5;
    pushKey = 1'b0;
    applyStimulus();
    checkOutput("lat_edge_k", 32'(serialValidIn), 32'd0);
    applyStimulus();
    checkOutput("lat_edge_k1", 32'(serialValidIn), 32'd0);
    applyStimulus();
    checkOutput("lat_edge_k2", 32'(serialValidIn), 32'd1);
    checkOutput("rx_head_a5", 32'(serialIn), 32'hA5);
    pushKey = 1'b1;
    idle(2);
    pressPush(8'h3C);
    readRx();
    checkOutput("rx_head_3c", 32'(serialIn), 32'h3C);
    readRx();
    checkOutput("rx_drained_valid", 32'(serialValidIn), 32'd0);
    checkOutput("rx_drained_count", 32'(rxCount), 32'd0);
    readRx();
    checkOutput("rx_empty_read_ovf", 32'(overflow), 32'd0);

    $display("[TB] RX overflow and key hold");
    for (int i = 0; i < 9; i++) pressPush(8'h40 + 8'(i));
    checkOutput("rx_full_count", 32'(rxCount), 32'd8);
    checkOutput("rx_full_ovf0", 32'(overflow[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rx_full_readback", 32'(serialIn), 32'(8'h40 + 8'(i)));
      readRx();
    end
    checkOutput("rx_ninth_absent", 32'(serialValidIn), 32'd0);
    swData  = 8'h99;
    pushKey = 1'b0;
    idle(100);
    pushKey = 1'b1;
    idle(3);
    checkOutput("hold_one_byte", 32'(rxCount), 32'd1);
    readRx();

    $display("[TB] TX fill and drain");
    doReset();
    for (int i = 0; i < 8; i++) writeTx(8'h10 + 8'(i));
    checkOutput("tx_full_ready", 32'(serialReadyIn), 32'd0);
    checkOutput("tx_full_ovf_clear", 32'(overflow[1]), 32'd0);
    writeTx(8'hEE);
    checkOutput("tx_full_ovf1", 32'(overflow[1]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("tx_drain_byte", 32'(txByte), 32'(8'h10 + 8'(i)));
      pressPop();
    end
    checkOutput("tx_drained_valid", 32'(txValid), 32'd0);
    pressPop();

    $display("[TB] Simultaneous write and pop");
    doReset();
    for (int i = 0; i < 3; i++) writeTx(8'h20 + 8'(i));
    popWithWrite(8'h23);
    checkOutput("simul_count", 32'(txCount), 32'd3);
    checkOutput("simul_head", 32'(txByte), 32'h21);
    for (int i = 0; i < 5; i++) writeTx(8'h30 + 8'(i));
    checkOutput("simul_full", 32'(txCount), 32'd8);
    popWithWrite(8'h77);
    checkOutput("simul_full_count", 32'(txCount), 32'd7);
    checkOutput("simul_full_ovf1", 32'(overflow[1]), 32'd1);

    $display("[TB] Wrap and asynchronous reset");
    doReset();
    for (int i = 0; i < 20; i++) begin
      data = 8'($urandom);
      pressPush(data);
      checkOutput("wrap_head", 32'(serialIn), 32'(data));
      readRx();
    end
    for (int i = 0; i < 5; i++) pressPush(8'h50 + 8'(i));
    checkOutput("pre_reset_count", 32'(rxCount), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rx_count", 32'(rxCount), 32'd0);
    checkOutput("async_valid", 32'(serialValidIn), 32'd0);
    resetModel();
    idle(2);
    reset = 1'b1;
    idle(2);

    $display("[TB] Random traffic");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) pushKey = ~pushKey;
      if ($urandom_range(3) == 0) popKey = ~popKey;
      swData        = 8'($urandom);
      serialOut     = 8'($urandom);
      serialRdenOut = 1'($urandom_range(1));
      serialWrenOut = ($urandom_range(2) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_console.md
# serial_console

Board-side responder for the processor's byte-serial port. The processor only initiates: it reads bytes via `serial_rden_out` and writes bytes via `serial_wren_out`. This block supplies the other end of both directions. Operator-entered switch bytes are queued in an RX FIFO and presented on `serial_in`/`serial_valid_in`. Processor-written bytes are queued in a TX FIFO and shown one at a time for the hex displays, advanced by a pushbutton. It sits between the processor and the board I/O, in place of the constant serial tie-offs.

## Interface
- `DEPTH`, 8: entries per FIFO; power of two, 2–16.
- `AW`, 3: pointer width; log2(`DEPTH`).
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `push_key` in 1: active-low pushbutton; a press enqueues `sw_data` into RX.
- `pop_key` in 1: active-low pushbutton; a press dequeues one TX byte.
- `sw_data` in 8: byte to enqueue.
- `serial_in` out 8: RX head byte, to the processor.
- `serial_valid_in` out 1: RX non-empty.
- `serial_rden_out` in 1: processor read strobe; pops RX.
- `serial_out` in 8: processor write data.
- `serial_wren_out` in 1: processor write strobe.
- `serial_ready_in` out 1: TX not full.
- `tx_byte` out 8: TX head byte, for display.
- `tx_valid` out 1: TX non-empty.
- `rx_count` out AW+1: RX occupancy, 0..DEPTH.
- `tx_count` out AW+1: TX occupancy, 0..DEPTH.
- `overflow` out 2: sticky error flags; bit0 = RX push while full, bit1 = TX write while full.

## Operation
- **Key handling:** each key passes through a 2-flop synchroniser, then a falling-edge detector that compares the sync output against its previous value. The result is a one-cycle pulse per press. Holding a key produces exactly one pulse. No debounce is done here; keys are debounced upstream.
- **RX FIFO push:** on a push pulse, if `rx_count < DEPTH`, write `sw_data` at the write pointer. Otherwise drop the byte and set `overflow[0]`.
- **RX FIFO pop:**
  - First-word fall-through: `serial_in` = mem[rd_ptr] and `serial_valid_in` = (rx_count != 0).
  - `serial_rden_out` pops only while `serial_valid_in` = 1. A read strobe while empty is ignored and does not set a flag.
- **TX FIFO write:** `serial_ready_in` = (tx_count != DEPTH). A `serial_wren_out` while ready writes `serial_out`. A write while not ready drops the byte and sets `overflow[1]`.
- **TX FIFO pop:** `tx_byte` = head and `tx_valid` = non-empty. A pop pulse while non-empty advances the head. A pop pulse while empty is ignored.
- **Empty outputs:** `serial_in` and `tx_byte` are forced to 8'h00 whenever their FIFO is empty.
- **Pointers:** AW bits, wrapping modulo DEPTH. Full and empty are derived from the counts, never from pointer equality.
- **Simultaneous push and pop on one FIFO, non-empty:** both occur in the same cycle and the count is unchanged.
- **Simultaneous push and pop, empty:** the push is accepted and the pop is ignored; count becomes 1.
- **Simultaneous push and pop, full:** the pop is accepted and the push is dropped (flag set), because space is judged on the pre-edge count.
- **Overflow flags:** cleared only by `reset`.

## Timing
- **Reset values:**
  - Synchroniser and previous-value flops = 1 (key released).
  - Pointers, counts and `overflow` = 0.
  - `serial_valid_in` = 0, `tx_valid` = 0, `serial_ready_in` = 1.
  - `serial_in` = 8'h00, `tx_byte` = 8'h00.
  - Memory contents are not reset; stale data is masked by the empty forcing.
- **Reset asserted mid-operation:** the state clears immediately and asynchronously, and all queued bytes are discarded.
- **Key latency:** if a key is first sampled low at edge k, the pulse is high during cycle k+1→k+2 and the FIFO updates at edge k+2. For RX this means `serial_valid_in`, `serial_in` and `rx_count` change after edge k+2.
- **Processor strobe latency:** strobes act at the same edge they are sampled. After that edge, count, valid, ready and head reflect the change, so there is zero-cycle handshake latency for back-to-back strobes.
- **Read data:** `serial_in` is valid in the same cycle that `serial_rden_out` is asserted. The next byte appears after that edge.

## Test plan
- **Reset:** hold `reset` = 0 → `serial_ready_in` = 1, `serial_valid_in` = 0, counts 0, `overflow` = 2'b00, `serial_in` = 8'h00.
- **RX order:** press `push_key` with `sw_data` = 8'hA5 then 8'h3C → `serial_valid_in` rises 2 edges after the first low sample; `serial_in` = A5. One `serial_rden_out` gives `serial_in` = 3C; a second gives valid = 0 and `rx_count` = 0.
- **RX overflow and hold:** 9 presses at DEPTH = 8 → `rx_count` = 8 and `overflow[0]` = 1. The 9th byte is absent on readback. Holding a key low for 100 cycles enqueues exactly one byte.
- **TX fill and drain:** 8 consecutive `serial_wren_out` with 8'h10..8'h17 → `serial_ready_in` = 0 after the 8th. A 9th write sets `overflow[1]`. 8 `pop_key` presses show `tx_byte` 10..17 in order, then `tx_valid` = 0.
- **Simultaneous events:** with `tx_count` = 3, assert a write and a pop pulse in the same cycle → `tx_count` stays 3 and the head advances. When full, a write plus pop gives count 7 and `overflow[1]` = 1.
- **Wrap and reset mid-operation:** push and pop alternately 20 times → data stays intact across pointer wrap. Then assert `reset` with `rx_count` = 5 → the count goes to 0 asynchronously, before the next clock edge.
